chip8_mem_ctrl: RTL and testbench

CHIP8_MEM_CTRL -- requirements
Module: chip8_mem_ctrl

---
 rtl/chip8_mem_if.sv | 31 +++
 rtl/chip8_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_chip8_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_if.sv
// +----------------------------------------------------------------------------
// | chip8_mem_if : CPU and program-loader bus of the CHIP-8 memory controller
// | Revision     : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface chip8_mem_if;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        load_done;
  logic [11:0] load_count;
  logic        load_err;
  logic        cpu_run;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, load_valid, load_data, load_done,
    input  cpu_rdata, load_ready, load_count, load_err, cpu_run
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, load_valid, load_data, load_done,
    output cpu_rdata, load_ready, load_count, load_err, cpu_run
  );
endinterface

`default_nettype wire

// File: rtl/chip8_mem_ctrl.sv
// +----------------------------------------------------------------------------
// | chip8_mem_ctrl : 4 KiB CHIP-8 memory with font init, program load and run
// | Revision       : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module chip8_mem_ctrl #(
  parameter logic [11:0] FONT_BASE = 12'h050,
  parameter logic [11:0] PROG_BASE = 12'h200
) (
  input logic         clk,
  input logic         reset,
  chip8_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    FONT_INIT = 2'd0,
    LOAD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [7:0] c_font [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };
  localparam logic [6:0] c_font_last = 7'd79;

  state_t      r_state;
  logic [6:0]  r_font_idx;
  logic [11:0] r_load_count;
  logic        r_load_err;
  logic        r_load_ready;
  logic        r_cpu_run;
  logic [7:0]  r_mem [4096];

  logic [11:0] w_load_addr;
  logic [11:0] w_font_addr;
  logic        w_load_xfer;
  logic        w_font_hit;
  logic        w_mem_we;
  logic [11:0] w_mem_addr;
  logic [7:0]  w_mem_wdata;

  assign w_load_addr = PROG_BASE + r_load_count;
  assign w_font_addr = FONT_BASE + {5'd0, r_font_idx};
  assign w_load_xfer = (r_state == LOAD) && bus.load_valid && r_load_ready;

  // Compare in 13 bits so a font window near the top of memory cannot wrap.
  assign w_font_hit = ({1'b0, bus.cpu_addr} >= {1'b0, FONT_BASE}) &&
                      ({1'b0, bus.cpu_addr} <  ({1'b0, FONT_BASE} + 13'd80));

  // Single write port shared by font init, loader and CPU.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.cpu_addr;
    w_mem_wdata = bus.cpu_wdata;
    case (r_state)
      FONT_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = w_font_addr;
        w_mem_wdata = c_font[r_font_idx];
      end
      LOAD: begin
        w_mem_we    = w_load_xfer;
        w_mem_addr  = w_load_addr;
        w_mem_wdata = bus.load_data;
      end
      RUN: begin
        w_mem_we    = bus.cpu_we && !w_font_hit;
      end
      default: begin
        w_mem_we    = 1'b0;
      end
    endcase
  end

  // Memory contents survive reset; only writes are suppressed while it is held.
  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FONT_INIT;
      r_font_idx   <= 7'd0;
      r_load_count <= 12'd0;
      r_load_err   <= 1'b0;
      r_load_ready <= 1'b0;
      r_cpu_run    <= 1'b0;
    end else begin
      case (r_state)
        FONT_INIT: begin
          if (r_font_idx == c_font_last) begin
            r_state      <= LOAD;
            r_load_ready <= 1'b1;
          end else begin
            r_font_idx   <= r_font_idx + 7'd1;
          end
        end
        LOAD: begin
          if (w_load_xfer) begin
            r_load_count <= r_load_count + 12'd1;
            if (w_load_addr == 12'hFFF) begin
              r_load_err   <= 1'b1;
              r_load_ready <= 1'b0;
            end
          end
          if (bus.load_done) begin
            r_state      <= RUN;
            r_load_ready <= 1'b0;
            r_cpu_run    <= 1'b1;
          end
        end
        RUN: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= FONT_INIT;
        end
      endcase
    end
  end

  assign bus.cpu_rdata  = r_cpu_run ? r_mem[bus.cpu_addr] : 8'h00;
  assign bus.load_ready = r_load_ready;
  assign bus.load_count = r_load_count;
  assign bus.load_err   = r_load_err;
  assign bus.cpu_run    = r_cpu_run;

endmodule

`default_nettype wire

// File: tb/tb_chip8_mem_ctrl.sv
// +----------------------------------------------------------------------------
// | tb_chip8_mem_ctrl : randomized scoreboard bench for chip8_mem_ctrl
// | Revision          : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_chip8_mem_ctrl;

  localparam int c_font_base = 'h050;
  localparam int c_prog_base = 'h200;

  typedef struct {
    string name;
    int    sel;   // 0 rdata, 1 load_count, 2 load_err, 3 load_ready, 4 cpu_run
    int    exp;
  } chk_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_req = 1'b0;

  chip8_mem_if bus ();

  chip8_mem_ctrl #(.FONT_BASE(12'h050), .PROG_BASE(12'h200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  chk_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: a plain byte array plus load bookkeeping.
  logic [7:0] m_mem [4096];
  bit         m_known [4096];
  bit         m_run, m_err;
  int         m_count;
  logic [39:0] c_glyph [16] = '{
    40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
    40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
    40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
    40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
  };

  function automatic logic [7:0] font_byte(input int k);
    logic [39:0] g;
    g = c_glyph[k / 5];
    return g[8 * (4 - (k % 5)) +: 8];
  endfunction

  // Monitor: consumes every queued expectation at the falling edge.
  chk_t mon_e;
  int   mon_act;
  always @(negedge clk) begin
    if (chk_req) begin
      while (q.size() > 0) begin
        mon_e = q.pop_front();
        case (mon_e.sel)
          0:       mon_act = int'(bus.cpu_rdata);
          1:       mon_act = int'(bus.load_count);
          2:       mon_act = int'(bus.load_err);
          3:       mon_act = int'(bus.load_ready);
          default: mon_act = int'(bus.cpu_run);
        endcase
        n_checks++;
        if (mon_act != mon_e.exp) begin
          n_errors++;
          $display("FAIL %s: got %0h, expected %0h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic expect_val(input string name, input int sel, input int exp);
    chk_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
    chk_req = 1'b1;
  endtask

  task automatic expect_status(input string tag);
    expect_val({tag, ":load_count"}, 1, m_count);
    expect_val({tag, ":load_err"},   2, int'(m_err));
    expect_val({tag, ":load_ready"}, 3, int'(!m_run && !m_err));
    expect_val({tag, ":cpu_run"},    4, int'(m_run));
  endtask

  task automatic expect_read(input logic [11:0] a);
    if (!m_run)
      expect_val($sformatf("rdata_idle[%03h]", a), 0, 0);
    else if (m_known[a])
      expect_val($sformatf("rdata[%03h]", a), 0, int'(m_mem[a]));
  endtask

  task automatic cpu_read(input logic [11:0] a);
    bus.cpu_addr = a;
    bus.cpu_we   = 1'b0;
    expect_read(a);
    step();
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    expect_read(a);
    step();
    bus.cpu_we = 1'b0;
    if (m_run && !(int'(a) >= c_font_base && int'(a) < c_font_base + 80)) begin
      m_mem[a]   = d;
      m_known[a] = 1'b1;
    end
  endtask

  task automatic load_byte(input logic [7:0] d, input logic done);
    int a;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_done  = done;
    step();
    bus.load_valid = 1'b0;
    bus.load_done  = 1'b0;
    if (!m_run && !m_err) begin
      a = c_prog_base + m_count;
      m_mem[a]   = d;
      m_known[a] = 1'b1;
      m_count++;
      if (a == 'hFFF) m_err = 1'b1;
    end
    if (done) m_run = 1'b1;
  endtask

  task automatic pulse_done();
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0;
    m_run = 1'b1;
  endtask

  task automatic reset_init(input int abort_at);
    step();
    reset = 1'b1;
    m_run = 1'b0; m_err = 1'b0; m_count = 0;
    bus.cpu_addr = 12'h050;
    expect_val("rst:load_count", 1, 0);
    expect_val("rst:load_err",   2, 0);
    expect_val("rst:load_ready", 3, 0);
    expect_val("rst:cpu_run",    4, 0);
    expect_val("rst:cpu_rdata",  0, 0);
    step();
    reset = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
    end
    for (int i = 1; i <= 80; i++) begin
      step();
      if (i == 79) expect_val("font_79:load_ready", 3, 0);
      if (i == 80) begin
        expect_val("font_80:load_ready", 3, 1);
        expect_val("font_80:cpu_run",    4, 0);
      end
    end
    for (int k = 0; k < 80; k++) begin
      m_mem[c_font_base + k]   = font_byte(k);
      m_known[c_font_base + k] = 1'b1;
    end
  endtask

  initial begin
    logic [11:0] a;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_done = 1'b0;
    m_run = 1'b0; m_err = 1'b0; m_count = 0;

    // load_done held from reset release: RUN after the 81st edge.
    bus.load_done = 1'b1;
    reset_init(0);
    step();
    bus.load_done = 1'b0;
    m_run = 1'b1;
    n_checks++;
    if (bus.cpu_run !== 1'b1) begin
      n_errors++;
      $display("FAIL direct run81: cpu_run = %b", bus.cpu_run);
    end
    bus.cpu_addr = 12'h050;
    #1;
    n_checks++;
    if (bus.cpu_rdata !== 8'hF0) begin
      n_errors++;
      $display("FAIL direct font[050]: got %02h", bus.cpu_rdata);
    end
    expect_status("run81");
    cpu_read(12'h050);
    cpu_read(12'h051);
    cpu_read(12'h09B);
    cpu_write(12'h300, 8'h55);
    cpu_write(12'h050, 8'h00);
    cpu_read(12'h300);
    cpu_read(12'h050);
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range('h040, 'h0AF)) : 12'($urandom);
      if ($urandom_range(0, 2) == 0) cpu_write(a, 8'($urandom));
      else                           cpu_read(a);
    end
    for (int k = 0; k < 80; k++) cpu_read(12'(c_font_base + k));

    // Short program with gaps; CPU writes during LOAD must be dropped.
    reset_init(0);
    cpu_write(12'h300, 8'hAA);
    cpu_read(12'h050);
    load_byte(8'h12, 1'b0);
    repeat ($urandom_range(1, 3)) step();
    load_byte(8'h34, 1'b0);
    repeat ($urandom_range(1, 3)) step();
    load_byte(8'hA2, 1'b0);
    step();
    expect_status("prog3");
    pulse_done();
    n_checks++;
    if (bus.load_count !== 12'd3 || bus.cpu_run !== 1'b1) begin
      n_errors++;
      $display("FAIL direct prog3: load_count = %0h cpu_run = %b", bus.load_count, bus.cpu_run);
    end
    expect_status("prog3_run");
    for (int i = 0; i < 3; i++) cpu_read(12'(c_prog_base + i));
    cpu_read(12'h300);

    // Reset mid-FONT_INIT, 10 bytes, reset mid-LOAD, then 2 bytes with done on the last.
    reset_init(30);
    for (int i = 0; i < 10; i++) begin
      load_byte(8'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) step();
    end
    expect_status("ten");
    step();
    reset_init(0);
    load_byte(8'($urandom), 1'b0);
    expect_status("reload1");
    load_byte(8'($urandom), 1'b1);
    n_checks++;
    if (bus.load_count !== 12'd2 || bus.load_err !== 1'b0) begin
      n_errors++;
      $display("FAIL direct reload: load_count = %0h load_err = %b", bus.load_count, bus.load_err);
    end
    expect_status("reload2_done");
    for (int i = 0; i < 10; i++) cpu_read(12'(c_prog_base + i));

    // Fill to the top of memory and overflow.
    reset_init(0);
    for (int i = 1; i <= 3584; i++) begin
      load_byte(8'($urandom), 1'b0);
      if (i == 3583) expect_status("fill_3583");
      if (i == 3584) expect_status("fill_3584");
      if ($urandom_range(0, 7) == 0) step();
    end
    for (int i = 0; i < 3; i++) begin
      load_byte(8'($urandom), 1'b0);
      expect_status("overflow_drop");
    end
    n_checks++;
    if (bus.load_err !== 1'b1 || bus.load_count !== 12'hE00 || bus.load_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL direct overflow: load_err = %b load_count = %0h load_ready = %b",
               bus.load_err, bus.load_count, bus.load_ready);
    end
    pulse_done();
    expect_status("overflow_run");
    cpu_read(12'hFFF);
    cpu_read(12'h200);
    for (int i = 0; i < 60; i++) cpu_read(12'($urandom_range(c_prog_base, 'hFFF)));
    cpu_read(12'h09B);

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    if (n_errors != 0) $display("FAIL: %0d errors", n_errors);
    else               $display("PASS");
    $finish;
  end

endmodule

`default_nettype wire
